// File: rtl/ov7670_stream_gen_pkg.sv
// Shared types and default geometry for the OV7670 camera stream generator.
// Holds the FSM state enum, default frame timing and counter-width helpers.
package ov7670_stream_gen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VBACK,
        ST_ACTIVE,
        ST_VFRONT
    } state_e;

    localparam int unsigned DEF_H_PIX         = 320;
    localparam int unsigned DEF_V_LINES       = 240;
    localparam int unsigned DEF_H_BLANK       = 144;
    localparam int unsigned DEF_VSYNC_LINES   = 3;
    localparam int unsigned DEF_V_BACK_LINES  = 17;
    localparam int unsigned DEF_V_FRONT_LINES = 10;

    localparam int unsigned LINE_T    = 2 * DEF_H_PIX + DEF_H_BLANK;
    localparam int unsigned FRAME_PIX = DEF_H_PIX * DEF_V_LINES;
    localparam int unsigned ADDR_W    = 17;

    function automatic int unsigned max2(input int unsigned a,
                                         input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed for a counter running 0..n-1 (at least one bit).
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ov7670_line_timer.sv
// Byte/line counters for the stream generator: byte position in the line,
// line index within the current FSM state, href window and line-end strobe.
// Ports: pclk, rst_n, run_i (counting), active_i (ACTIVE state),
// line_clr_i (state ends), byte_cnt_o, line_cnt_o, href_o, line_end_o.
module ov7670_line_timer
    import ov7670_stream_gen_pkg::*;
#(
    parameter int unsigned H_PIX   = DEF_H_PIX,
    parameter int unsigned H_BLANK = DEF_H_BLANK,
    parameter int unsigned BW      = 10,
    parameter int unsigned LW      = 8
) (
    input  logic          pclk,
    input  logic          rst_n,
    input  logic          run_i,
    input  logic          active_i,
    input  logic          line_clr_i,
    output logic [BW-1:0] byte_cnt_o,
    output logic [LW-1:0] line_cnt_o,
    output logic          href_o,
    output logic          line_end_o
);

    localparam int unsigned LT = 2 * H_PIX + H_BLANK;
    localparam logic [BW-1:0] B_LAST = BW'(LT - 1);
    localparam logic [BW-1:0] B_ACT  = BW'(2 * H_PIX);

    logic [BW-1:0] byte_q, byte_d;
    logic [LW-1:0] line_q, line_d;
    logic          line_end;

    assign line_end = run_i && (byte_q == B_LAST);

    always_comb begin
        byte_d = byte_q + 1'b1;
        if (!run_i || line_end) begin
            byte_d = '0;
        end
    end

    // The line count restarts whenever the FSM leaves a state, so each
    // state counts its own lines from zero.
    always_comb begin
        line_d = line_q;
        if (!run_i || line_clr_i) begin
            line_d = '0;
        end else if (line_end) begin
            line_d = line_q + 1'b1;
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            byte_q <= '0;
            line_q <= '0;
        end else begin
            byte_q <= byte_d;
            line_q <= line_d;
        end
    end

    assign byte_cnt_o = byte_q;
    assign line_cnt_o = line_q;
    assign line_end_o = line_end;
    assign href_o     = active_i && (byte_q < B_ACT);

endmodule

// File: rtl/ov7670_stream_gen.sv
// OV7670-style camera stream generator: reads RGB565 pixels from a
// synchronous frame buffer and emits vsync/href/d byte timing.
// Ports: pclk, rst_n, enable; rd_addr/rd_en/rd_data RAM port;
// vsync, href, d (pixel byte), frame_done (last cycle of each frame).
module ov7670_stream_gen
    import ov7670_stream_gen_pkg::*;
#(
    parameter int unsigned H_PIX         = DEF_H_PIX,
    parameter int unsigned V_LINES       = DEF_V_LINES,
    parameter int unsigned H_BLANK       = DEF_H_BLANK,
    parameter int unsigned VSYNC_LINES   = DEF_VSYNC_LINES,
    parameter int unsigned V_BACK_LINES  = DEF_V_BACK_LINES,
    parameter int unsigned V_FRONT_LINES = DEF_V_FRONT_LINES
) (
    input  logic              pclk,
    input  logic              rst_n,
    input  logic              enable,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    input  logic [15:0]       rd_data,
    output logic              vsync,
    output logic              href,
    output logic [7:0]        d,
    output logic              frame_done
);

    localparam int unsigned LT   = 2 * H_PIX + H_BLANK;
    localparam int unsigned FPIX = H_PIX * V_LINES;
    localparam int unsigned BW   = cnt_w(LT);
    localparam int unsigned LW   = cnt_w(max2(max2(V_LINES, VSYNC_LINES),
                                              max2(V_BACK_LINES, V_FRONT_LINES)));

    localparam logic [LW-1:0] L_SYNC  = LW'(VSYNC_LINES - 1);
    localparam logic [LW-1:0] L_BACK  = LW'(V_BACK_LINES - 1);
    localparam logic [LW-1:0] L_ACT   = LW'(V_LINES - 1);
    localparam logic [LW-1:0] L_FRONT = LW'(V_FRONT_LINES - 1);
    localparam logic [BW-1:0] B_WRAP  = BW'(LT - 2);
    localparam logic [BW-1:0] B_INMAX = BW'(2 * H_PIX - 2);
    localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(FPIX - 1);

    state_e            state_q, state_d;
    logic [BW-1:0]     byte_cnt;
    logic [LW-1:0]     line_cnt;
    logic              line_end;
    logic              last_line;
    logic              state_end;
    logic              fetch;
    logic              fetch_in;
    logic              fetch_wrap;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              fetch_q;
    logic [15:0]       pix_q, pix_d;

    ov7670_line_timer #(
        .H_PIX   (H_PIX),
        .H_BLANK (H_BLANK),
        .BW      (BW),
        .LW      (LW)
    ) u_timer (
        .pclk       (pclk),
        .rst_n      (rst_n),
        .run_i      (state_q != ST_IDLE),
        .active_i   (state_q == ST_ACTIVE),
        .line_clr_i (state_end),
        .byte_cnt_o (byte_cnt),
        .line_cnt_o (line_cnt),
        .href_o     (href),
        .line_end_o (line_end)
    );

    always_comb begin
        last_line = 1'b0;
        case (state_q)
            ST_VSYNC:  last_line = (line_cnt == L_SYNC);
            ST_VBACK:  last_line = (line_cnt == L_BACK);
            ST_ACTIVE: last_line = (line_cnt == L_ACT);
            ST_VFRONT: last_line = (line_cnt == L_FRONT);
            default:   last_line = 1'b0;
        endcase
    end

    assign state_end = line_end && last_line;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // enable is only consulted in IDLE and on the final VFRONT cycle,
    // so dropping it mid-frame lets the frame run to completion.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (enable) state_d = ST_VSYNC;
            ST_VSYNC:  if (state_end) state_d = ST_VBACK;
            ST_VBACK:  if (state_end) state_d = ST_ACTIVE;
            ST_ACTIVE: if (state_end) state_d = ST_VFRONT;
            ST_VFRONT: if (state_end) state_d = enable ? ST_VSYNC : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // A pixel is fetched two cycles before its high byte goes out. The
    // first pixel of a line is fetched in the tail of the previous line
    // (or of the last back-porch line for line 0).
    always_comb begin
        vsync      = (state_q == ST_VSYNC);
        frame_done = (state_q == ST_VFRONT) && state_end;
        fetch_in   = (state_q == ST_ACTIVE) && (byte_cnt < B_INMAX);
        fetch_wrap = (byte_cnt == B_WRAP) &&
                     (((state_q == ST_ACTIVE) && !last_line) ||
                      ((state_q == ST_VBACK) && last_line));
        fetch      = !byte_cnt[0] && (fetch_in || fetch_wrap);
        rd_en      = fetch;
    end

    always_comb begin
        addr_d = addr_q;
        if ((state_q != ST_VSYNC) && (state_d == ST_VSYNC)) begin
            addr_d = '0;
        end else if (fetch && (addr_q != A_LAST)) begin
            addr_d = addr_q + 1'b1;
        end
    end

    assign pix_d = fetch_q ? rd_data : pix_q;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            fetch_q <= 1'b0;
            pix_q   <= '0;
        end else begin
            addr_q  <= addr_d;
            fetch_q <= fetch;
            pix_q   <= pix_d;
        end
    end

    assign rd_addr = addr_q;
    assign d = !href ? 8'h00 : (byte_cnt[0] ? pix_q[7:0] : pix_q[15:8]);

endmodule

// File: tb/tb_ov7670_stream_gen.sv
// Self-checking bench for ov7670_stream_gen on a reduced 4x3 geometry.
// Traces two frames, then checks table vectors, counts and reset behaviour.
module tb_ov7670_stream_gen;

    localparam int NT = 230;

    logic        pclk  = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [16:0] rd_addr;
    logic        rd_en;
    logic [15:0] rd_data = '0;
    logic        vsync;
    logic        href;
    logic [7:0]  d;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          cyc;
        logic        vs;
        logic        hr;
        logic [7:0]  dd;
        logic        en;
        logic [16:0] ad;
        logic        fd;
    } vec_t;

    vec_t vt[$];

    logic        tr_vs[NT];
    logic        tr_hr[NT];
    logic [7:0]  tr_d[NT];
    logic        tr_en[NT];
    logic [16:0] tr_ad[NT];
    logic        tr_fd[NT];

    always #5 pclk = ~pclk;

    // Synchronous RAM model: high byte A0+addr, low byte addr.
    always @(posedge pclk) begin
        if (rd_en) rd_data <= {8'hA0 + rd_addr[7:0], rd_addr[7:0]};
    end

    ov7670_stream_gen #(
        .H_PIX         (4),
        .V_LINES       (3),
        .H_BLANK       (4),
        .VSYNC_LINES   (2),
        .V_BACK_LINES  (2),
        .V_FRONT_LINES (2)
    ) dut (
        .pclk       (pclk),
        .rst_n      (rst_n),
        .enable     (enable),
        .rd_addr    (rd_addr),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .vsync      (vsync),
        .href       (href),
        .d          (d),
        .frame_done (frame_done)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {3'b0, vsync, href, d, rd_en, rd_addr, frame_done};
    endfunction

    initial begin
        int n_hr, n_rise, n_en, n_fd, n_vs, bad, quiet;

        vt.push_back('{0,   1, 0, 8'h00, 0, 17'd0,  0});
        vt.push_back('{23,  1, 0, 8'h00, 0, 17'd0,  0});
        vt.push_back('{24,  0, 0, 8'h00, 0, 17'd0,  0});
        vt.push_back('{45,  0, 0, 8'h00, 0, 17'd0,  0});
        vt.push_back('{46,  0, 0, 8'h00, 1, 17'd0,  0});
        vt.push_back('{47,  0, 0, 8'h00, 0, 17'd1,  0});
        vt.push_back('{48,  0, 1, 8'hA0, 1, 17'd1,  0});
        vt.push_back('{49,  0, 1, 8'h00, 0, 17'd2,  0});
        vt.push_back('{50,  0, 1, 8'hA1, 1, 17'd2,  0});
        vt.push_back('{51,  0, 1, 8'h01, 0, 17'd3,  0});
        vt.push_back('{54,  0, 1, 8'hA3, 0, 17'd4,  0});
        vt.push_back('{55,  0, 1, 8'h03, 0, 17'd4,  0});
        vt.push_back('{56,  0, 0, 8'h00, 0, 17'd4,  0});
        vt.push_back('{58,  0, 0, 8'h00, 1, 17'd4,  0});
        vt.push_back('{60,  0, 1, 8'hA4, 1, 17'd5,  0});
        vt.push_back('{61,  0, 1, 8'h04, 0, 17'd6,  0});
        vt.push_back('{70,  0, 0, 8'h00, 1, 17'd8,  0});
        vt.push_back('{72,  0, 1, 8'hA8, 1, 17'd9,  0});
        vt.push_back('{79,  0, 1, 8'h0B, 0, 17'd11, 0});
        vt.push_back('{82,  0, 0, 8'h00, 0, 17'd11, 0});
        vt.push_back('{84,  0, 0, 8'h00, 0, 17'd11, 0});
        vt.push_back('{106, 0, 0, 8'h00, 0, 17'd11, 0});
        vt.push_back('{107, 0, 0, 8'h00, 0, 17'd11, 1});
        vt.push_back('{108, 1, 0, 8'h00, 0, 17'd0,  0});
        vt.push_back('{156, 0, 1, 8'hA0, 1, 17'd1,  0});
        vt.push_back('{215, 0, 0, 8'h00, 0, 17'd11, 1});
        vt.push_back('{216, 0, 0, 8'h00, 0, 17'd11, 0});
        vt.push_back('{229, 0, 0, 8'h00, 0, 17'd11, 0});

        // Reset state and idle behaviour with enable low.
        repeat (2) @(negedge pclk);
        chk("reset_outputs", outs(), 32'h0);
        rst_n = 1'b1;
        repeat (5) @(negedge pclk);
        chk("idle_after_reset", outs(), 32'h0);

        // Two frames; enable dropped mid ACTIVE of the second frame.
        enable = 1'b1;
        for (int t = 0; t < NT; t++) begin
            @(negedge pclk);
            tr_vs[t] = vsync;
            tr_hr[t] = href;
            tr_d[t]  = d;
            tr_en[t] = rd_en;
            tr_ad[t] = rd_addr;
            tr_fd[t] = frame_done;
            if (t == 170) enable = 1'b0;
        end

        foreach (vt[i]) begin
            chk($sformatf("vec_t%0d", vt[i].cyc),
                {3'b0, tr_vs[vt[i].cyc], tr_hr[vt[i].cyc], tr_d[vt[i].cyc],
                 tr_en[vt[i].cyc], tr_ad[vt[i].cyc], tr_fd[vt[i].cyc]},
                {3'b0, vt[i].vs, vt[i].hr, vt[i].dd, vt[i].en, vt[i].ad,
                 vt[i].fd});
        end

        for (int f = 0; f < 2; f++) begin
            n_hr = 0; n_rise = 0; n_en = 0; n_fd = 0; n_vs = 0;
            for (int t = f * 108; t < f * 108 + 108; t++) begin
                if (tr_hr[t]) n_hr++;
                if (tr_hr[t] && (t == 0 || !tr_hr[t-1])) n_rise++;
                if (tr_en[t]) n_en++;
                if (tr_fd[t]) n_fd++;
                if (tr_vs[t]) n_vs++;
            end
            chk($sformatf("f%0d_href_cycles", f), n_hr, 24);
            chk($sformatf("f%0d_href_pulses", f), n_rise, 3);
            chk($sformatf("f%0d_rd_en_count", f), n_en, 12);
            chk($sformatf("f%0d_frame_done", f), n_fd, 1);
            chk($sformatf("f%0d_vsync_cycles", f), n_vs, 24);
        end

        // Every byte of the active region against a small pixel model.
        for (int f = 0; f < 2; f++) begin
            bad = 0;
            for (int t = 48 + f * 108; t < 84 + f * 108; t++) begin
                int b, ln, px;
                logic [7:0] ed;
                logic eh;
                b  = (t - 48 - f * 108) % 12;
                ln = (t - 48 - f * 108) / 12;
                px = 4 * ln + b / 2;
                eh = (b < 8);
                ed = !eh ? 8'h00 :
                     (b % 2 == 1) ? 8'(px) : 8'(8'hA0 + px);
                if (tr_hr[t] !== eh || tr_d[t] !== ed) bad++;
            end
            chk($sformatf("f%0d_byte_stream", f), bad, 0);
        end

        quiet = 0;
        for (int t = 216; t < NT; t++) begin
            if (tr_vs[t] || tr_hr[t] || tr_en[t]) quiet++;
        end
        chk("idle_after_drop", quiet, 0);

        // Asynchronous reset in the middle of an active line.
        enable = 1'b1;
        repeat (51) @(negedge pclk);
        chk("pre_reset_line", {href, d}, {1'b1, 8'hA1});
        #2 rst_n = 1'b0;
        #1 chk("async_reset", outs(), 32'h0);
        enable = 1'b0;
        repeat (3) @(negedge pclk);
        rst_n = 1'b1;
        quiet = 0;
        repeat (30) begin
            @(negedge pclk);
            if (rd_en || vsync || href) quiet++;
        end
        chk("quiet_after_reset", quiet, 0);
        enable = 1'b1;
        @(negedge pclk);
        chk("restart_vsync", {vsync, rd_addr}, {1'b1, 17'd0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ov7670_stream_gen.md
OV7670_STREAM_GEN -- requirements
Module: ov7670_stream_gen

Interface
REQ-001 Parameter H_PIX, default 320, active pixels per line.
REQ-002 Parameter V_LINES, default 240, active lines per frame.
REQ-003 Parameter H_BLANK, default 144, href-low cycles after each line's active bytes.
REQ-004 Parameter VSYNC_LINES / V_BACK_LINES / V_FRONT_LINES, defaults 3 / 17 / 10, line periods of sync, back porch and front porch.
REQ-005 pclk  input  1  sole clock; every output changes only on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 enable  input  1  level; frames are generated while high.
REQ-008 rd_addr  output  17  frame-buffer read address, pixel index 0..H_PIX*V_LINES-1.
REQ-009 rd_en  output  1  read strobe to a synchronous RAM.
REQ-010 rd_data  input  16  RGB565 pixel, valid the cycle after rd_en.
REQ-011 vsync  output  1  frame sync, active high.
REQ-012 href  output  1  high during active bytes of a line.
REQ-013 d  output  8  pixel byte bus.
REQ-014 frame_done  output  1  single-cycle pulse at end of each frame.

Function
REQ-015 Line period SHALL be LINE_T = 2*H_PIX + H_BLANK cycles (784 by default); one byte per pclk.
REQ-016 The FSM SHALL have states IDLE, VSYNC, VBACK, ACTIVE, VFRONT, with transitions IDLE->VSYNC, VSYNC->VBACK, VBACK->ACTIVE, ACTIVE->VFRONT, and VFRONT->VSYNC or VFRONT->IDLE.
REQ-017 IDLE->VSYNC SHALL occur on the first cycle enable=1 is sampled in IDLE.
REQ-018 VSYNC SHALL hold vsync=1 for VSYNC_LINES*LINE_T cycles, and vsync SHALL be 0 in every other state.
REQ-019 VBACK SHALL last V_BACK_LINES*LINE_T cycles, and VFRONT SHALL last V_FRONT_LINES*LINE_T cycles.
REQ-020 ACTIVE SHALL last V_LINES*LINE_T cycles; each line is href=1 for the first 2*H_PIX cycles, then href=0 for H_BLANK cycles.
REQ-021 During href=1, d SHALL carry the pixel high byte rd_data[15:8] then the low byte rd_data[7:0], so pixel k occupies line bytes 2k and 2k+1.
REQ-022 When href=0, d SHALL be 8'h00.
REQ-023 Read timing: rd_en=1 with rd_addr=A in cycle N; rd_data for A is sampled in N+1; the high byte of A appears on d in N+2; exactly one read per pixel.
REQ-024 rd_addr SHALL start each frame at 0, increment by 1 per pixel across lines without reset at line ends, and never exceed H_PIX*V_LINES-1 (76799).
REQ-025 rd_en SHALL be 0 outside the pre-fetch windows of REQ-023.
REQ-026 frame_done SHALL pulse for exactly one cycle on the last VFRONT cycle.
REQ-027 On that last VFRONT cycle, enable=1 SHALL give VFRONT->VSYNC with no gap cycle, and enable=0 SHALL give VFRONT->IDLE.
REQ-028 Deasserting enable mid-frame SHALL NOT truncate the frame; the block finishes it and then enters IDLE.
REQ-029 Line, byte and porch counters SHALL be sized from the parameters and SHALL wrap only at their terminal counts.

Reset
REQ-030 While rst_n=0, the block SHALL be in IDLE with vsync=0, href=0, d=0, rd_en=0, rd_addr=0, frame_done=0, and all counters at 0.
REQ-031 rst_n SHALL assert asynchronously at any point, including mid-line, aborting the frame.
REQ-032 After rst_n deasserts, the first frame SHALL begin only via REQ-017.

Structure
REQ-033 A shared package SHALL hold the FSM state enum, default geometry constants (320, 240, 144, 3, 17, 10), and the derived LINE_T and FRAME_PIX=76800.
REQ-034 One sub-module, ov7670_line_timer, SHALL generate byte/line counts, href and line-end strobes, while the top holds the FSM, address and byte mux.

Verification
REQ-035 Reset release, enable=1 -> vsync rises 1 cycle later and stays high 2352 cycles, then 13328 cycles low before the first href rise.
REQ-036 RAM model returning data=address -> line 0 bytes are 00,00,00,01,00,02,...; byte 639 = 8'h3F; href high exactly 640 cycles, then low 144.
REQ-037 Full frame -> 240 href pulses, rd_en count = 76800, last rd_addr = 76799, one frame_done pulse, frame length 270*784 = 211680 cycles.
REQ-038 enable held high -> vsync of frame 2 rises the cycle after frame_done; rd_addr restarts at 0.
REQ-039 enable dropped at line 100 -> frame completes all 240 lines, then IDLE with vsync=0 and href=0.
REQ-040 rst_n pulsed low mid-line -> outputs 0 asynchronously, with no further rd_en until a new frame starts per REQ-017.
